// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - memory-mapped GPIO port: direction, set/clr/tgl, synced input, edge IRQ
// Optional blink output modulation is built when GPIO_BLINK_EN is defined.
module gpio_port #(
   parameter int unsigned       N_PINS    = 8,
   parameter logic [N_PINS-1:0] RST_OUT   = '0,
   parameter int unsigned       BLINK_DIV = 25_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [3:0]        addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   input  logic [N_PINS-1:0] gpio_in,
   output logic [N_PINS-1:0] gpio_out,
   output logic [N_PINS-1:0] gpio_oe,
   output logic              irq
);

   localparam logic [3:0] A_OUT   = 4'd0;
   localparam logic [3:0] A_DIR   = 4'd1;
   localparam logic [3:0] A_IN    = 4'd2;
   localparam logic [3:0] A_SET   = 4'd3;
   localparam logic [3:0] A_CLR   = 4'd4;
   localparam logic [3:0] A_TGL   = 4'd5;
   localparam logic [3:0] A_STAT  = 4'd6;
   localparam logic [3:0] A_IEN   = 4'd7;
   localparam logic [3:0] A_POL   = 4'd8;
   localparam logic [3:0] A_BLINK = 4'd9;

   logic [N_PINS-1:0] w;
   logic              wr;
   logic [N_PINS-1:0] out_q, dir_q, stat_q, ien_q, pol_q;
   logic [N_PINS-1:0] s1, s2, s3;
   logic [N_PINS-1:0] ev_raw, ev, w1c_mask;
   logic [1:0]        warm_q;
   logic [N_PINS-1:0] rd;
   logic              unused_wdata;

   assign w            = wdata[N_PINS-1:0];
   assign wr           = en & we;
   assign unused_wdata = ^wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= RST_OUT;
         dir_q <= '0;
         ien_q <= '0;
         pol_q <= '0;
      end else if (wr) begin
         case (addr)
            A_OUT:   out_q <= w;
            A_DIR:   dir_q <= w;
            A_SET:   out_q <= out_q | w;
            A_CLR:   out_q <= out_q & ~w;
            A_TGL:   out_q <= out_q ^ w;
            A_IEN:   ien_q <= w;
            A_POL:   pol_q <= w;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1     <= '0;
         s2     <= '0;
         s3     <= '0;
         warm_q <= 2'd0;
      end else begin
         s1 <= gpio_in;
         s2 <= s1;
         s3 <= s2;
         if (warm_q != 2'd3)
            warm_q <= warm_q + 2'd1;
      end
   end

   // Events are masked until the synchroniser has flushed its reset zeros,
   // so pins held high through reset do not look like rising edges.
   assign ev_raw   = (pol_q & ~s2 & s3) | (~pol_q & s2 & ~s3);
   assign ev       = (warm_q == 2'd3) ? ev_raw : '0;
   assign w1c_mask = (wr && addr == A_STAT) ? w : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stat_q <= '0;
      else
         stat_q <= (stat_q & ~w1c_mask) | ev;
   end

   assign irq     = |(stat_q & ien_q);
   assign gpio_oe = dir_q;

`ifdef GPIO_BLINK_EN
   localparam int unsigned PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [PW-1:0]     pre_q;
   logic              phase_q;
   logic [N_PINS-1:0] blink_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q   <= '0;
         phase_q <= 1'b0;
         blink_q <= '0;
      end else begin
         if (pre_q == PW'(BLINK_DIV - 1)) begin
            pre_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            pre_q <= pre_q + PW'(1);
         end
         if (wr && addr == A_BLINK)
            blink_q <= w;
      end
   end

   assign gpio_out = out_q ^ (blink_q & {N_PINS{phase_q}});
`else
   logic unused_blink_div;
   assign unused_blink_div = (BLINK_DIV == 0);
   assign gpio_out         = out_q;
`endif

   always_comb begin
      rd = '0;
      if (en) begin
         case (addr)
            A_OUT:   rd = out_q;
            A_DIR:   rd = dir_q;
            A_IN:    rd = s2;
            A_STAT:  rd = stat_q;
            A_IEN:   rd = ien_q;
            A_POL:   rd = pol_q;
`ifdef GPIO_BLINK_EN
            A_BLINK: rd = blink_q;
`endif
            default: rd = '0;
         endcase
      end
   end

   assign rdata = 32'(rd);

endmodule

// File: tb/tb_gpio_port.sv
// tb/tb_gpio_port.sv - scoreboard bench for gpio_port (N_PINS=8, RST_OUT=A5, BLINK_DIV=4)
module tb_gpio_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  gpio_in, gpio_out, gpio_oe;
   logic        irq;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   gpio_port #(.N_PINS(8), .RST_OUT(8'hA5), .BLINK_DIV(4)) dut (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .gpio_oe(gpio_oe), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty: observed %h required <none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      en = 1'b1; we = 1'b1; addr = a; wdata = d;
      tick();
      en = 1'b0; we = 1'b0; wdata = '0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      en = 1'b1; we = 1'b0; addr = a;
      #1;
      d = rdata;
      en = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      push(tag, exp);
      bus_read(a, d);
      observe(d);
   endtask

   task automatic check_sig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      push(tag, exp);
      observe(obs);
   endtask

   initial begin
      logic [31:0] d;
      logic        v;
      logic        found;

      rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
      repeat (3) tick();
      check_sig("rst_gpio_out", 32'(gpio_out), 32'h0000_00A5);
      check_sig("rst_gpio_oe", 32'(gpio_oe), 32'h0);
      check_sig("rst_irq", 32'(irq), 32'h0);
      rst = 1'b0;
      check_reg("rst_read_out", 4'd0, 32'h0000_00A5);
      check_reg("rst_read_stat", 4'd6, 32'h0);

      push("out_wr", 32'h0F);   bus_write(4'd0, 32'h0F); observe(32'(gpio_out));
      push("out_set", 32'h3F);  bus_write(4'd3, 32'h30); observe(32'(gpio_out));
      push("out_clr", 32'h3C);  bus_write(4'd4, 32'h03); observe(32'(gpio_out));
      push("out_tgl", 32'hC3);  bus_write(4'd5, 32'hFF); observe(32'(gpio_out));
      check_reg("read_set_zero", 4'd3, 32'h0);
      check_reg("read_clr_zero", 4'd4, 32'h0);
      check_reg("read_tgl_zero", 4'd5, 32'h0);
      check_reg("read_out_after_tgl", 4'd0, 32'hC3);

      bus_write(4'd0, 32'hFFFF_FF12);
      check_reg("out_upper_dropped", 4'd0, 32'h12);
      check_reg("unmapped_c", 4'hC, 32'h0);
      check_reg("unmapped_9", 4'd9, 32'h0);
      addr = 4'd0; en = 1'b0; #1;
      check_sig("rdata_en_low", rdata, 32'h0);

      bus_write(4'd1, 32'h5A);
      check_sig("gpio_oe_dir", 32'(gpio_oe), 32'h5A);
      check_reg("read_dir", 4'd1, 32'h5A);

      bus_write(4'd7, 32'h01);
      bus_write(4'd8, 32'h00);
      gpio_in[0] = 1'b1;
      tick();
      check_reg("in_t1", 4'd2, 32'h00);
      tick();
      check_reg("in_t2", 4'd2, 32'h01);
      check_reg("stat_t2", 4'd6, 32'h00);
      check_sig("irq_t2", 32'(irq), 32'h0);
      tick();
      check_reg("stat_t3", 4'd6, 32'h01);
      check_sig("irq_t3", 32'(irq), 32'h1);
      bus_write(4'd6, 32'h01);
      check_sig("irq_after_w1c", 32'(irq), 32'h0);
      check_reg("stat_after_w1c", 4'd6, 32'h00);

      gpio_in[0] = 1'b0;
      repeat (3) tick();
      check_reg("stat_fall_pol0", 4'd6, 32'h00);
      gpio_in[0] = 1'b1;
      repeat (3) tick();
      gpio_in[0] = 1'b0;
      repeat (3) tick();
      check_reg("stat_held", 4'd6, 32'h01);
      gpio_in[0] = 1'b1;
      tick();
      tick();
      bus_write(4'd6, 32'h01);
      check_reg("stat_event_beats_w1c", 4'd6, 32'h01);
      check_sig("irq_event_beats_w1c", 32'(irq), 32'h1);
      bus_write(4'd6, 32'h01);
      check_reg("stat_cleared", 4'd6, 32'h00);

      bus_write(4'd8, 32'h01);
      check_reg("stat_after_pol", 4'd6, 32'h00);
      gpio_in[0] = 1'b0;
      tick();
      tick();
      check_reg("stat_fall_t2", 4'd6, 32'h00);
      tick();
      check_reg("stat_fall_t3", 4'd6, 32'h01);
      check_sig("irq_fall", 32'(irq), 32'h1);
      bus_write(4'd6, 32'h01);
      bus_write(4'd8, 32'h00);

      gpio_in[1] = 1'b1;
      repeat (3) tick();
      check_reg("stat_pin1", 4'd6, 32'h02);
      check_sig("irq_masked", 32'(irq), 32'h0);

      gpio_in = 8'hFF;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      check_reg("warmup_stat", 4'd6, 32'h00);
      check_reg("warmup_in", 4'd2, 32'hFF);
      check_reg("warmup_out", 4'd0, 32'hA5);
      check_sig("warmup_oe", 32'(gpio_oe), 32'h00);

`ifdef GPIO_BLINK_EN
      bus_write(4'd0, 32'h00);
      bus_write(4'd9, 32'h01);
      check_reg("read_blink", 4'd9, 32'h01);
      v = gpio_out[0];
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (gpio_out[0] !== v) found = 1'b1;
      end
      check_sig("blink_toggle_seen", 32'(found), 32'h1);
      v = gpio_out[0];
      for (int k = 1; k <= 12; k++) begin
         tick();
         push("blink_phase", 32'(v ^ ((k / 4) % 2 == 1)));
         observe(32'(gpio_out[0]));
         check_sig("blink_upper_pins", 32'(gpio_out[7:1]), 32'h0);
      end
      check_reg("blink_out_readback", 4'd0, 32'h00);
      #2;
      rst = 1'b1;
      #1;
      check_sig("blink_async_rst", 32'(gpio_out), 32'hA5);
      tick();
      rst = 1'b0;
`endif

      if (sb.size() != 0) begin
         n_err++;
         $error("FAIL scoreboard_leftover: observed %0d required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
